// File: rtl/symbol_aligner.sv
// Purpose: K28.5 comma word aligner between the deserializer and the elastic buffer. Optional SYMBOL_ALIGNER_LOSS_CNT_EN adds lock_loss_count.
// Latency: 1 cycle from data_in to data_out.
// Backpressure: none; data_in_valid low freezes all alignment state and drops the output strobes.
module symbol_aligner #(
    parameter int LOCK_COUNT     = 3,
    parameter int MISALIGN_LIMIT = 4
) (
    input  logic       recovered_clock,
    input  logic       recovered_reset,
    input  logic [9:0] data_in,
    input  logic       data_in_valid,
    output logic [9:0] data_out,
    output logic       data_out_valid,
    output logic       comma_detected,
    output logic       locked,
    output logic [3:0] offset
`ifdef SYMBOL_ALIGNER_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_count
`endif
);

    localparam logic [9:0] COMMA_NEG = 10'b0011111010;
    localparam logic [9:0] COMMA_POS = 10'b1100000101;
    localparam logic [3:0] LOCK_CNT  = 4'(LOCK_COUNT);
    localparam logic [3:0] MIS_LIM   = 4'(MISALIGN_LIMIT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  prev_word;
    logic [3:0]  match_cnt;
    logic [3:0]  match_cnt_nxt;
    logic [3:0]  misalign_cnt;
    logic [3:0]  misalign_cnt_nxt;
    logic [3:0]  offset_nxt;
    logic [19:0] window;
    logic [9:0]  cand [16];
    logic [15:0] match;
    logic [3:0]  first_k;
    logic        any_match;
    logic        match_cur;

    assign window = {prev_word, data_in};

    // Offsets 10..15 are unreachable; they stay zero so a 4-bit index is always in range.
    always_comb begin
        match = '0;
        for (int k = 0; k < 16; k++) begin
            cand[k] = '0;
            if (k < 10) begin
                cand[k]  = window[19-k -: 10];
                match[k] = (cand[k] == COMMA_NEG) || (cand[k] == COMMA_POS);
            end
        end
    end

    // Scan downward so the lowest matching offset is the one that sticks.
    always_comb begin
        first_k = '0;
        for (int k = 9; k >= 0; k--) begin
            if (match[k]) begin
                first_k = 4'(k);
            end
        end
    end

    assign any_match = |match;
    assign match_cur = match[offset];

    always_comb begin
        state_nxt        = state;
        offset_nxt       = offset;
        match_cnt_nxt    = match_cnt;
        misalign_cnt_nxt = misalign_cnt;
        if (data_in_valid && any_match) begin
            unique case (state)
                HUNT: begin
                    offset_nxt    = first_k;
                    match_cnt_nxt = 4'd1;
                    state_nxt     = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                end
                VERIFY: begin
                    if (match_cur) begin
                        if (match_cnt + 4'd1 >= LOCK_CNT) begin
                            match_cnt_nxt = LOCK_CNT;
                            state_nxt     = LOCKED;
                        end else begin
                            match_cnt_nxt = match_cnt + 4'd1;
                        end
                    end else begin
                        offset_nxt    = first_k;
                        match_cnt_nxt = 4'd1;
                    end
                end
                LOCKED: begin
                    // The word boundary is frozen here; only the misalign counter moves.
                    if (match_cur) begin
                        misalign_cnt_nxt = '0;
                    end else if (misalign_cnt + 4'd1 >= MIS_LIM) begin
                        state_nxt        = HUNT;
                        match_cnt_nxt    = '0;
                        misalign_cnt_nxt = '0;
                    end else begin
                        misalign_cnt_nxt = misalign_cnt + 4'd1;
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge recovered_clock or negedge recovered_reset) begin
        if (!recovered_reset) begin
            state        <= HUNT;
            offset       <= '0;
            match_cnt    <= '0;
            misalign_cnt <= '0;
        end else begin
            state        <= state_nxt;
            offset       <= offset_nxt;
            match_cnt    <= match_cnt_nxt;
            misalign_cnt <= misalign_cnt_nxt;
        end
    end

    always_ff @(posedge recovered_clock or negedge recovered_reset) begin
        if (!recovered_reset) begin
            prev_word      <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            comma_detected <= 1'b0;
        end else if (data_in_valid) begin
            prev_word      <= data_in;
            data_out       <= cand[offset_nxt];
            data_out_valid <= (state_nxt == LOCKED);
            comma_detected <= match[offset_nxt];
        end else begin
            data_out_valid <= 1'b0;
            comma_detected <= 1'b0;
        end
    end

    assign locked = (state == LOCKED);

`ifdef SYMBOL_ALIGNER_LOSS_CNT_EN
    always_ff @(posedge recovered_clock or negedge recovered_reset) begin
        if (!recovered_reset) begin
            lock_loss_count <= '0;
        end else if ((state == LOCKED) && (state_nxt == HUNT) && (lock_loss_count != 8'hFF)) begin
            lock_loss_count <= lock_loss_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_symbol_aligner.sv
// Randomized scoreboard bench for symbol_aligner: a bit-stream generator feeds words, a
// behavioural model predicts each cycle's outputs, and a monitor process compares them.
module tb_symbol_aligner;

    localparam int LC = 3;
    localparam int ML = 4;
    localparam logic [9:0] K_NEG = 10'b0011111010;
    localparam logic [9:0] K_POS = 10'b1100000101;
    localparam int S_HUNT   = 0;
    localparam int S_VERIFY = 1;
    localparam int S_LOCKED = 2;

    logic       recovered_clock = 1'b0;
    logic       recovered_reset;
    logic [9:0] data_in;
    logic       data_in_valid;
    logic [9:0] data_out;
    logic       data_out_valid;
    logic       comma_detected;
    logic       locked;
    logic [3:0] offset;
`ifdef SYMBOL_ALIGNER_LOSS_CNT_EN
    logic [7:0] lock_loss_count;
`endif

    typedef struct packed {
        logic [9:0] dout;
        logic       vld;
        logic       comma;
        logic       lock;
        logic [3:0] off;
        logic [7:0] loss;
    } exp_t;

    exp_t       expq[$];
    exp_t       mon_e;
    bit         bitq[$];
    int         checks   = 0;
    int         failures = 0;

    int         m_state, m_off, m_mc, m_mis, m_loss;
    logic [9:0] m_prev, m_dout;

    symbol_aligner #(
        .LOCK_COUNT     (LC),
        .MISALIGN_LIMIT (ML)
    ) dut (
        .recovered_clock (recovered_clock),
        .recovered_reset (recovered_reset),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .data_out        (data_out),
        .data_out_valid  (data_out_valid),
        .comma_detected  (comma_detected),
        .locked          (locked),
        .offset          (offset)
`ifdef SYMBOL_ALIGNER_LOSS_CNT_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    always #5 recovered_clock = ~recovered_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic bit is_comma(input logic [9:0] w);
        return (w == K_NEG) || (w == K_POS);
    endfunction

    function automatic int max_run(input logic [9:0] w);
        int run  = 1;
        int best = 1;
        for (int i = 8; i >= 0; i--) begin
            if (w[i] == w[i+1]) run++;
            else run = 1;
            if (run > best) best = run;
        end
        return best;
    endfunction

    // Runs of at most two equal bits can never form the 5-bit run every comma needs.
    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (max_run(w) > 2);
        return w;
    endfunction

    task automatic model_reset();
        m_state = S_HUNT;
        m_off   = 0;
        m_mc    = 0;
        m_mis   = 0;
        m_loss  = 0;
        m_prev  = '0;
        m_dout  = '0;
    endtask

    task automatic model_step(input logic v, input logic [9:0] din, output exp_t e);
        logic [19:0] win;
        int          hit_lo;
        bit          hit_cur;
        e = '0;
        if (v) begin
            win    = {m_prev, din};
            hit_lo = -1;
            for (int j = 9; j >= 0; j--)
                if (is_comma(10'(win >> (10 - j)))) hit_lo = j;
            hit_cur = is_comma(10'(win >> (10 - m_off)));
            if (hit_lo >= 0) begin
                if (m_state == S_HUNT) begin
                    m_off   = hit_lo;
                    m_mc    = 1;
                    m_state = (LC == 1) ? S_LOCKED : S_VERIFY;
                end else if (m_state == S_VERIFY) begin
                    if (hit_cur) begin
                        m_mc = m_mc + 1;
                        if (m_mc >= LC) begin
                            m_mc    = LC;
                            m_state = S_LOCKED;
                        end
                    end else begin
                        m_off = hit_lo;
                        m_mc  = 1;
                    end
                end else begin
                    if (hit_cur) m_mis = 0;
                    else m_mis = m_mis + 1;
                    if (m_mis >= ML) begin
                        m_state = S_HUNT;
                        m_mc    = 0;
                        m_mis   = 0;
                        if (m_loss < 255) m_loss = m_loss + 1;
                    end
                end
            end
            m_dout  = 10'(win >> (10 - m_off));
            e.vld   = (m_state == S_LOCKED);
            e.comma = is_comma(m_dout);
            m_prev  = din;
        end
        e.dout = m_dout;
        e.lock = (m_state == S_LOCKED);
        e.off  = 4'(m_off);
        e.loss = 8'(m_loss);
    endtask

    always @(posedge recovered_clock) begin
        #2;
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            checks++;
            if ({data_out, data_out_valid, comma_detected, locked, offset} !==
                {mon_e.dout, mon_e.vld, mon_e.comma, mon_e.lock, mon_e.off}) begin
                failures++;
                $display("FAIL scoreboard t=%0t: got dout=%b vld=%b comma=%b lock=%b off=%0d, need dout=%b vld=%b comma=%b lock=%b off=%0d",
                         $time, data_out, data_out_valid, comma_detected, locked, offset,
                         mon_e.dout, mon_e.vld, mon_e.comma, mon_e.lock, mon_e.off);
            end
`ifdef SYMBOL_ALIGNER_LOSS_CNT_EN
            checks++;
            if (lock_loss_count !== mon_e.loss) begin
                failures++;
                $display("FAIL scoreboard_loss t=%0t: got %0d need %0d", $time, lock_loss_count, mon_e.loss);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d need %0d", name, act, exp);
        end
    endtask

    task automatic drive_word(input logic v, input logic [9:0] w);
        exp_t e;
        @(negedge recovered_clock);
        data_in       = w;
        data_in_valid = v;
        model_step(v, w, e);
        expq.push_back(e);
        @(posedge recovered_clock);
        #1;
    endtask

    task automatic push_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) bitq.push_back(s[i]);
    endtask

    task automatic push_slip(input int n);
        for (int i = 0; i < n; i++) bitq.push_back(i[0]);
    endtask

    task automatic drain(input int gap_pct);
        logic [9:0] w;
        while (bitq.size() >= 10) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) drive_word(1'b0, 10'($urandom));
            for (int i = 9; i >= 0; i--) w[i] = bitq.pop_front();
            drive_word(1'b1, w);
        end
    endtask

    // A trailing data symbol guarantees the comma's tail bits have been delivered.
    task automatic send_comma();
        push_sym(($urandom_range(1) != 0) ? K_POS : K_NEG);
        push_sym(rand_data());
        drain(0);
    endtask

    task automatic do_reset();
        #2;
        data_in_valid   = 1'b0;
        recovered_reset = 1'b0;
        #1;
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_data_out_valid", 32'(data_out_valid), 0);
        chk("rst_comma_detected", 32'(comma_detected), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_offset", 32'(offset), 0);
`ifdef SYMBOL_ALIGNER_LOSS_CNT_EN
        chk("rst_lock_loss_count", 32'(lock_loss_count), 0);
`endif
        model_reset();
        expq.delete();
        bitq.delete();
        repeat (2) @(posedge recovered_clock);
        @(negedge recovered_clock);
        recovered_reset = 1'b1;
    endtask

    initial begin
        recovered_reset = 1'b0;
        data_in         = '0;
        data_in_valid   = 1'b0;
        model_reset();
        do_reset();

        // Aligned comma stream: the first comma is only visible once it becomes prev_word.
        for (int i = 1; i <= 4; i++) begin
            drive_word(1'b1, K_NEG);
            chk("s1_locked", 32'(locked), 32'(i >= 4));
            if (i >= 2) chk("s1_offset", 32'(offset), 0);
        end
        chk("s1_data_out_valid", 32'(data_out_valid), 1);
        chk("s1_comma_detected", 32'(comma_detected), 1);
        chk("s1_data_out", 32'(data_out), 32'(K_NEG));

        // Stream rotated by 3 bits.
        do_reset();
        push_slip(3);
        push_sym(rand_data());
        push_sym(rand_data());
        drain(0);
        chk("s2_unlocked_before_commas", 32'(locked), 0);
        for (int c = 1; c <= 3; c++) begin
            send_comma();
            chk("s2_locked", 32'(locked), 32'(c == 3));
            chk("s2_offset", 32'(offset), 3);
        end
        for (int i = 0; i < 3; i++) push_sym(rand_data());
        drain(0);
        chk("s2_locked_hold", 32'(locked), 1);

        // Four commas at a foreign offset (7) drop lock; three more relock there.
        push_slip(4);
        push_sym(rand_data());
        drain(0);
        for (int c = 1; c <= 4; c++) begin
            send_comma();
            chk("s3_locked_foreign", 32'(locked), 32'(c < 4));
            if (c < 4) chk("s3_offset_frozen", 32'(offset), 3);
        end
`ifdef SYMBOL_ALIGNER_LOSS_CNT_EN
        chk("s3_lock_loss_count", 32'(lock_loss_count), 1);
`endif
        for (int c = 1; c <= 3; c++) begin
            send_comma();
            chk("s3_relock", 32'(locked), 32'(c == 3));
        end
        chk("s3_offset_new", 32'(offset), 7);

        // A correct-offset comma between foreign ones clears the misalign count.
        push_slip(6);
        for (int c = 1; c <= 2; c++) begin
            send_comma();
            chk("s4_locked_a", 32'(locked), 1);
        end
        push_slip(4);
        send_comma();
        chk("s4_locked_good", 32'(locked), 1);
        push_slip(6);
        for (int c = 1; c <= 3; c++) begin
            send_comma();
            chk("s4_locked_b", 32'(locked), 1);
            chk("s4_offset", 32'(offset), 7);
        end
        push_slip(4);
        push_sym(rand_data());
        drain(0);
`ifdef SYMBOL_ALIGNER_LOSS_CNT_EN
        chk("s4_lock_loss_count", 32'(lock_loss_count), 1);
`endif

        // Five-cycle valid gap mid-stream.
        send_comma();
        for (int i = 0; i < 5; i++) begin
            drive_word(1'b0, 10'($urandom));
            chk("s5_gap_valid", 32'(data_out_valid), 0);
            chk("s5_gap_locked", 32'(locked), 1);
            chk("s5_gap_offset", 32'(offset), 7);
        end
        send_comma();
        chk("s5_after_locked", 32'(locked), 1);
        chk("s5_after_offset", 32'(offset), 7);

        // Asynchronous reset while locked.
        chk("s6_locked_before", 32'(locked), 1);
        do_reset();

        // Random traffic: occasional bit slips, commas of both disparities, valid gaps.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(99));
            if (r < 3) push_slip(int'($urandom_range(9, 1)));
            if (r < 28) push_sym(($urandom_range(1) != 0) ? K_POS : K_NEG);
            else push_sym(rand_data());
            drain(10);
        end
        push_sym(rand_data());
        push_sym(rand_data());
        drain(0);

        for (int i = 0; i < 20 && expq.size() > 0; i++) begin
            @(posedge recovered_clock);
            #3;
        end
        if (expq.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending need 0", expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/symbol_aligner.md
Name: symbol_aligner

Overview:
- Sits in the RX path directly upstream of the elastic buffer, on the recovered clock domain.
- Takes unaligned 10-bit words from the deserializer and hunts for the K28.5 comma at any of 10 bit offsets.
- Locks the word boundary and delivers aligned 10-bit symbols, with a valid strobe, to the elastic buffer write side.

Parameters:
- LOCK_COUNT, 3, commas required at one offset to declare lock (1..15).
- MISALIGN_LIMIT, 4, consecutive commas at a foreign offset that drop lock (1..15).

Ports:
- recovered_clock  input  1  recovered RX clock; all logic is on its rising edge.
- recovered_reset  input  1  asynchronous, active-low reset.
- data_in  input  10  raw deserialized word; bit 9 is the earliest received bit.
- data_in_valid  input  1  qualifies data_in.
- data_out  output  10  aligned symbol; bit 9 is the earliest bit.
- data_out_valid  output  1  data_out is an aligned symbol; this is the elastic buffer write enable.
- comma_detected  output  1  data_out holds a K28.5 comma.
- locked  output  1  alignment is locked.
- offset  output  4  current alignment offset, 0..9.

Behaviour:
- Reset values (asynchronous, active-low): all outputs 0, prev_word 0, state HUNT, counters 0.
- Window: window[19:0] = {prev_word, data_in}. The candidate word at offset k is window[19-k -: 10].
- prev_word loads data_in on every valid cycle.
- Comma match: candidate equals 10'b0011111010 or 10'b1100000101.
  - If several offsets match in one window, the lowest k wins.
- data_in_valid low: state, counters, prev_word and offset are all held; data_out_valid and comma_detected are 0 next cycle; data_out holds.
- Latency: 1 cycle. On a valid input at edge t, data_out at t+1 is the window slice at the offset chosen for that cycle (the next_offset value, below).
- State machine (transitions are evaluated only on valid cycles with a comma match; non-comma valid words cause no transition):
  - HUNT:
    - Match at k: offset becomes k, the match counter becomes 1, go to VERIFY.
    - If LOCK_COUNT is 1, go directly to LOCKED instead.
  - VERIFY:
    - Match at the current offset: the match counter increments. When it reaches LOCK_COUNT, go to LOCKED.
    - Match at another offset k: offset becomes k, the match counter becomes 1, stay in VERIFY.
  - LOCKED:
    - Offset is frozen.
    - Match at the current offset: the misalign counter clears.
    - Match only at a foreign offset: the misalign counter increments.
    - When the misalign counter reaches MISALIGN_LIMIT: go to HUNT, clear counters, offset holds.
- next_offset: the new k on a HUNT/VERIFY realignment; otherwise the current offset.
- Output flags:
  - data_out_valid = 1 for a valid input when the next state is LOCKED. This includes the word that completes lock; the word that causes loss of lock outputs with valid 0.
  - comma_detected = 1 when the registered data_out is a comma at the current offset.
  - locked = 1 when state is LOCKED.
- Counter widths: 4 bits. The match counter saturates at LOCK_COUNT.
- Reset mid-stream: everything returns immediately to its reset value; the first post-reset window uses prev_word = 0.

Optional Feature:
- Macro: SYMBOL_ALIGNER_LOSS_CNT_EN.
- With the macro:
  - Extra output port lock_loss_count, 8 bits.
  - Increments on each LOCKED -> HUNT transition and saturates at 255.
  - Reset value 0.
- Without the macro: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then a stream of data_in = 10'b0011111010 words (offset 0) with LOCK_COUNT = 3 -> offset = 0; locked rises on the edge after the 3rd comma; that word appears on data_out with data_out_valid = 1 and comma_detected = 1.
- Stream rotated by 3 bits: commas split across words, random D-symbols between commas -> offset = 3; locked after 3 commas; data_out reproduces the original symbols in order, with 1-cycle latency.
- While locked at offset 3, inject 4 commas at offset 7 -> locked stays 1 after the 3rd and drops after the 4th (data_out_valid = 0 for that word); realigns to 7 after 3 further commas.
- Same as the previous scenario, but with a correct-offset comma after the 2nd foreign comma -> the misalign counter clears and lock is retained through 3 further foreign commas.
- Toggle data_in_valid low for 5 cycles mid-stream -> no state change; data_out_valid = 0 during the gap; alignment is preserved after the gap.
- Assert recovered_reset low while locked -> all outputs 0 asynchronously (before the next edge), state HUNT. With SYMBOL_ALIGNER_LOSS_CNT_EN defined, lock_loss_count = 0 after reset and equals 1 after the loss in the third scenario.
